// File: rtl/cuckoo_kick_controller.sv
// cuckoo_kick_controller
// Control FSM for inserting one entry into a cuckoo hash table. It accepts an
// insert request and issues it to the hash pipeline. When the pipeline evicts
// a resident entry, that entry becomes the new pending entry and is re-issued.
// This repeats until the pipeline reports an empty slot (success) or until
// MAX_KICKS re-insertions have been used. In the second case the last evicted
// entry is reported as lost.
//
// Ports
//   clk, reset       : rising-edge clock; asynchronous active-low reset
//   clk_en           : global enable, 0 freezes every register
//   req_*            : insert request channel (valid/ready)
//   op_*             : insert operation towards the hash pipeline (valid/ready)
//   res_*            : pipeline result; res_key_i/res_data_i carry the evicted
//                      entry when res_evicted_i=1
//   done_*           : one-cycle completion report with ok flag and entry
//   busy_o           : high whenever an insert is in progress
module cuckoo_kick_controller #(
    parameter int DATA_WIDTH = 4,
    parameter int KEY_WIDTH  = 2,
    parameter int MAX_KICKS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [KEY_WIDTH-1:0]  req_key_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  op_valid_o,
    input  logic                  op_ready_i,
    output logic [KEY_WIDTH-1:0]  op_key_o,
    output logic [DATA_WIDTH-1:0] op_data_o,
    input  logic                  res_valid_i,
    input  logic                  res_evicted_i,
    input  logic [KEY_WIDTH-1:0]  res_key_i,
    input  logic [DATA_WIDTH-1:0] res_data_i,
    output logic                  done_valid_o,
    output logic                  done_ok_o,
    output logic [KEY_WIDTH-1:0]  done_key_o,
    output logic [DATA_WIDTH-1:0] done_data_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] KICK_LIMIT = 8'(MAX_KICKS);

    state_t                state_q, state_d;
    logic [7:0]            kick_cnt_q, kick_cnt_d;
    logic [KEY_WIDTH-1:0]  pend_key_q, pend_key_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                  done_ok_q, done_ok_d;
    logic [KEY_WIDTH-1:0]  done_key_q, done_key_d;
    logic [DATA_WIDTH-1:0] done_data_q, done_data_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            kick_cnt_q  <= '0;
            pend_key_q  <= '0;
            pend_data_q <= '0;
            done_ok_q   <= 1'b0;
            done_key_q  <= '0;
            done_data_q <= '0;
        end else begin
            state_q     <= state_d;
            kick_cnt_q  <= kick_cnt_d;
            pend_key_q  <= pend_key_d;
            pend_data_q <= pend_data_d;
            done_ok_q   <= done_ok_d;
            done_key_q  <= done_key_d;
            done_data_q <= done_data_d;
        end
    end

    // Every register holds by default. clk_en=0 skips the whole case
    // statement, so a disabled cycle never changes state.
    always_comb begin
        state_d     = state_q;
        kick_cnt_d  = kick_cnt_q;
        pend_key_d  = pend_key_q;
        pend_data_d = pend_data_q;
        done_ok_d   = done_ok_q;
        done_key_d  = done_key_q;
        done_data_d = done_data_q;
        if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        pend_key_d  = req_key_i;
                        pend_data_d = req_data_i;
                        kick_cnt_d  = '0;
                        state_d     = ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_ready_i) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (res_valid_i) begin
                        if (!res_evicted_i) begin
                            // The slot was free. The last issued entry is now stored.
                            state_d     = DONE;
                            done_ok_d   = 1'b1;
                            done_key_d  = pend_key_q;
                            done_data_d = pend_data_q;
                        end else if (kick_cnt_q < KICK_LIMIT) begin
                            // A kick budget remains, so re-insert the displaced entry.
                            pend_key_d  = res_key_i;
                            pend_data_d = res_data_i;
                            kick_cnt_d  = kick_cnt_q + 8'd1;
                            state_d     = ISSUE;
                        end else begin
                            // The budget is exhausted. Report the displaced entry as lost.
                            state_d     = DONE;
                            done_ok_d   = 1'b0;
                            done_key_d  = res_key_i;
                            done_data_d = res_data_i;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign op_valid_o   = (state_q == ISSUE);
    assign op_key_o     = pend_key_q;
    assign op_data_o    = pend_data_q;
    assign done_valid_o = (state_q == DONE);
    assign done_ok_o    = done_ok_q;
    assign done_key_o   = done_key_q;
    assign done_data_o  = done_data_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_cuckoo_kick_controller.sv
module tb_cuckoo_kick_controller;

    localparam int KW = 2;
    localparam int DW = 4;
    localparam int MK = 4;

    logic          clk;
    logic          reset;
    logic          clk_en;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [KW-1:0] req_key_i;
    logic [DW-1:0] req_data_i;
    logic          op_valid_o;
    logic          op_ready_i;
    logic [KW-1:0] op_key_o;
    logic [DW-1:0] op_data_o;
    logic          res_valid_i;
    logic          res_evicted_i;
    logic [KW-1:0] res_key_i;
    logic [DW-1:0] res_data_i;
    logic          done_valid_o;
    logic          done_ok_o;
    logic [KW-1:0] done_key_o;
    logic [DW-1:0] done_data_o;
    logic          busy_o;

    int checks = 0;
    int passes = 0;

    // One insert transaction. The pipeline answers result i with the evicted
    // entry ev[i] while i < n_ev, and with "no eviction" after that.
    typedef struct {
        logic [KW-1:0]        key;
        logic [DW-1:0]        data;
        int                   n_ev;
        logic [5:0][KW-1:0]   ev_key;
        logic [5:0][DW-1:0]   ev_data;
        int                   exp_ops;
        logic                 exp_ok;
        logic [KW-1:0]        exp_key;
        logic [DW-1:0]        exp_data;
    } txn_t;

    txn_t tbl[5];

    cuckoo_kick_controller #(
        .DATA_WIDTH(DW),
        .KEY_WIDTH (KW),
        .MAX_KICKS (MK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_key_i    (req_key_i),
        .req_data_i   (req_data_i),
        .op_valid_o   (op_valid_o),
        .op_ready_i   (op_ready_i),
        .op_key_o     (op_key_o),
        .op_data_o    (op_data_o),
        .res_valid_i  (res_valid_i),
        .res_evicted_i(res_evicted_i),
        .res_key_i    (res_key_i),
        .res_data_i   (res_data_i),
        .done_valid_o (done_valid_o),
        .done_ok_o    (done_ok_o),
        .done_key_o   (done_key_o),
        .done_data_o  (done_data_o),
        .busy_o       (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Transaction-level reference. Every eviction within the kick budget adds
    // one operation. The first eviction past the budget loses that entry.
    function automatic txn_t modelExpect(input txn_t t);
        txn_t r = t;
        if (t.n_ev <= MK) begin
            r.exp_ops = t.n_ev + 1;
            r.exp_ok  = 1'b1;
            if (t.n_ev == 0) begin
                r.exp_key  = t.key;
                r.exp_data = t.data;
            end else begin
                r.exp_key  = t.ev_key[t.n_ev-1];
                r.exp_data = t.ev_data[t.n_ev-1];
            end
        end else begin
            r.exp_ops  = MK + 1;
            r.exp_ok   = 1'b0;
            r.exp_key  = t.ev_key[MK];
            r.exp_data = t.ev_data[MK];
        end
        return r;
    endfunction

    // Drives a full insert transaction, acting as both requester and hash
    // pipeline. Inputs change on the falling edge. Outputs are sampled there too.
    task automatic applyStimulus(input txn_t t, input bit stall, input bit noise);
        bit            accepted = 0;
        bit            waiting  = 0;
        bit            finished = 0;
        bit            prev_hold = 0;
        int            n_op = 0;
        int            res_idx = 0;
        int            delay = 0;
        logic [KW-1:0] hold_key = '0;
        logic [DW-1:0] hold_data = '0;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_key_i   = t.key;
        req_data_i  = t.data;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (accepted) req_valid_i = 1'b0;
            clk_en        = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            op_ready_i    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            res_valid_i   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            res_evicted_i = 1'($urandom);
            res_key_i     = KW'($urandom);
            res_data_i    = DW'($urandom);
            if (prev_hold) begin
                checkOutput("op_stable", 32'({op_valid_o, op_key_o, op_data_o}),
                            32'({1'b1, hold_key, hold_data}));
            end
            prev_hold = 0;
            if (!accepted) begin
                if (req_ready_o && clk_en) accepted = 1;
            end else if (op_valid_o) begin
                checkOutput("busy_in_issue", 32'(busy_o), 32'd1);
                if (op_ready_i && clk_en) begin
                    if (n_op > MK) begin
                        checkOutput("op_count_limit", 32'(n_op + 1), 32'(MK + 1));
                    end else if (n_op == 0) begin
                        checkOutput("op_entry", 32'({op_key_o, op_data_o}), 32'({t.key, t.data}));
                    end else begin
                        checkOutput("op_entry", 32'({op_key_o, op_data_o}),
                                    32'({t.ev_key[n_op-1], t.ev_data[n_op-1]}));
                    end
                    n_op++;
                    waiting = 1;
                    delay = stall ? $urandom_range(0, 2) : 0;
                end else begin
                    prev_hold = 1;
                    hold_key  = op_key_o;
                    hold_data = op_data_o;
                end
            end else if (done_valid_o) begin
                if (clk_en) begin
                    checkOutput("done_ok", 32'(done_ok_o), 32'(t.exp_ok));
                    checkOutput("done_key", 32'(done_key_o), 32'(t.exp_key));
                    checkOutput("done_data", 32'(done_data_o), 32'(t.exp_data));
                    checkOutput("op_count", 32'(n_op), 32'(t.exp_ops));
                    checkOutput("ready_in_done", 32'(req_ready_o), 32'd0);
                    finished = 1;
                end
            end else if (waiting) begin
                if (delay > 0) begin
                    res_valid_i = 1'b0;
                    delay--;
                end else begin
                    res_valid_i   = 1'b1;
                    res_evicted_i = (res_idx < t.n_ev);
                    if (res_idx < 6) begin
                        res_key_i  = t.ev_key[res_idx];
                        res_data_i = t.ev_data[res_idx];
                    end
                    if (clk_en) begin
                        res_idx++;
                        waiting = 0;
                    end
                end
            end
            @(negedge clk);
        end
        if (!finished) begin
            checkOutput("txn_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("done_one_cycle", 32'(done_valid_o), 32'd0);
            checkOutput("idle_ready", 32'({req_ready_o, busy_o}), 32'b10);
            checkOutput("done_hold", 32'({done_key_o, done_data_o}), 32'({t.exp_key, t.exp_data}));
        end
        req_valid_i = 1'b0;
        res_valid_i = 1'b0;
        clk_en      = 1'b1;
        op_ready_i  = 1'b1;
    endtask

    initial begin
        txn_t t;

        // Directed vectors whose expected outcome is written out by hand.
        tbl[0] = '{key: 2'd2, data: 4'd5, n_ev: 0, ev_key: '0, ev_data: '0,
                   exp_ops: 1, exp_ok: 1'b1, exp_key: 2'd2, exp_data: 4'd5};
        tbl[1] = '{key: 2'd1, data: 4'd3, n_ev: 1, ev_key: '0, ev_data: '0,
                   exp_ops: 2, exp_ok: 1'b1, exp_key: 2'd2, exp_data: 4'd9};
        tbl[1].ev_key[0] = 2'd2; tbl[1].ev_data[0] = 4'd9;
        tbl[2] = '{key: 2'd0, data: 4'd1, n_ev: 5, ev_key: '0, ev_data: '0,
                   exp_ops: 5, exp_ok: 1'b0, exp_key: 2'd3, exp_data: 4'd7};
        tbl[2].ev_key[0] = 2'd1; tbl[2].ev_data[0] = 4'd2;
        tbl[2].ev_key[1] = 2'd2; tbl[2].ev_data[1] = 4'd4;
        tbl[2].ev_key[2] = 2'd3; tbl[2].ev_data[2] = 4'd6;
        tbl[2].ev_key[3] = 2'd0; tbl[2].ev_data[3] = 4'd8;
        tbl[2].ev_key[4] = 2'd3; tbl[2].ev_data[4] = 4'd7;
        tbl[3] = '{key: 2'd3, data: 4'd15, n_ev: 4, ev_key: '0, ev_data: '0,
                   exp_ops: 5, exp_ok: 1'b1, exp_key: 2'd3, exp_data: 4'd4};
        tbl[3].ev_key[0] = 2'd0; tbl[3].ev_data[0] = 4'd1;
        tbl[3].ev_key[1] = 2'd1; tbl[3].ev_data[1] = 4'd2;
        tbl[3].ev_key[2] = 2'd2; tbl[3].ev_data[2] = 4'd3;
        tbl[3].ev_key[3] = 2'd3; tbl[3].ev_data[3] = 4'd4;
        tbl[4] = '{key: 2'd1, data: 4'd0, n_ev: 3, ev_key: '0, ev_data: '0,
                   exp_ops: 4, exp_ok: 1'b1, exp_key: 2'd0, exp_data: 4'd12};
        tbl[4].ev_key[0] = 2'd2; tbl[4].ev_data[0] = 4'd10;
        tbl[4].ev_key[1] = 2'd3; tbl[4].ev_data[1] = 4'd11;
        tbl[4].ev_key[2] = 2'd0; tbl[4].ev_data[2] = 4'd12;

        reset = 1'b0; clk_en = 1'b1; req_valid_i = 1'b0; req_key_i = '0; req_data_i = '0;
        op_ready_i = 1'b1; res_valid_i = 1'b0; res_evicted_i = 1'b0; res_key_i = '0; res_data_i = '0;

        // The design must hold its reset values while reset is low.
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", 32'({op_valid_o, done_valid_o, done_ok_o, busy_o}), 32'd0);
        checkOutput("reset_done_entry", 32'({done_key_o, done_data_o}), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'({req_ready_o, busy_o}), 32'b10);

        for (int i = 0; i < 5; i++) applyStimulus(tbl[i], 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(tbl[i], 1'b1, 1'b1);

        // op_ready_i is held low while clk_en toggles. The operation must stay
        // stable and complete with a single handshake.
        @(negedge clk);
        req_valid_i = 1'b1; req_key_i = 2'd1; req_data_i = 4'd6; op_ready_i = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_en = 1'(i % 2);
            checkOutput("stall_op", 32'({op_valid_o, op_key_o, op_data_o}), 32'({1'b1, 2'd1, 4'd6}));
            @(negedge clk);
        end
        clk_en = 1'b0; op_ready_i = 1'b1;
        @(negedge clk);
        checkOutput("stall_frozen", 32'(op_valid_o), 32'd1);
        clk_en = 1'b1;
        @(negedge clk);
        checkOutput("stall_handshake", 32'({op_valid_o, busy_o}), 32'b01);
        res_valid_i = 1'b1; res_evicted_i = 1'b0;
        @(negedge clk);
        res_valid_i = 1'b0;
        checkOutput("stall_done", 32'({done_valid_o, done_ok_o, done_key_o, done_data_o}),
                    32'({1'b1, 1'b1, 2'd1, 4'd6}));
        @(negedge clk);
        checkOutput("stall_idle", 32'({done_valid_o, op_valid_o, req_ready_o}), 32'b001);

        // Reset while waiting for a result. A result that arrives afterwards must be ignored.
        req_valid_i = 1'b1; req_key_i = 2'd3; req_data_i = 4'd12;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("wait_busy", 32'({busy_o, op_valid_o}), 32'b10);
        #2 reset = 1'b0;
        #1 checkOutput("async_reset", 32'({busy_o, op_valid_o, done_valid_o, done_ok_o}), 32'd0);
        checkOutput("async_reset_entry", 32'({done_key_o, done_data_o}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        res_valid_i = 1'b1; res_evicted_i = 1'b0; res_key_i = 2'd1; res_data_i = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            res_valid_i = 1'b0;
            checkOutput("no_done_after_reset", 32'({done_valid_o, busy_o, req_ready_o}), 32'b001);
        end

        // Back-to-back requests with req_valid_i held high throughout.
        req_valid_i = 1'b1; req_key_i = 2'd2; req_data_i = 4'd1;
        @(negedge clk);
        checkOutput("b2b_issue1", 32'(op_valid_o), 32'd1);
        @(negedge clk);
        checkOutput("b2b_wait1", 32'({op_valid_o, req_ready_o}), 32'b00);
        res_valid_i = 1'b1; res_evicted_i = 1'b0;
        @(negedge clk);
        res_valid_i = 1'b0;
        checkOutput("b2b_done1", 32'({done_valid_o, req_ready_o}), 32'b10);
        @(negedge clk);
        checkOutput("b2b_idle", 32'({req_ready_o, done_valid_o, op_valid_o}), 32'b100);
        @(negedge clk);
        checkOutput("b2b_issue2", 32'({op_valid_o, busy_o}), 32'b11);
        req_valid_i = 1'b0;
        @(negedge clk);
        res_valid_i = 1'b1; res_evicted_i = 1'b0;
        @(negedge clk);
        res_valid_i = 1'b0;
        checkOutput("b2b_done2", 32'({done_valid_o, done_ok_o, done_key_o, done_data_o}),
                    32'({1'b1, 1'b1, 2'd2, 4'd1}));
        @(negedge clk);

        // Randomized transactions checked against the reference model.
        for (int n = 0; n < 30; n++) begin
            t.key  = KW'($urandom);
            t.data = DW'($urandom);
            t.n_ev = $urandom_range(0, 6);
            for (int j = 0; j < 6; j++) begin
                t.ev_key[j]  = KW'($urandom);
                t.ev_data[j] = DW'($urandom);
            end
            t = modelExpect(t);
            applyStimulus(t, 1'b1, 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
